cordic_seq: RTL

CORDIC_SEQ -- requirements
Module: cordic_seq

---
 rtl/cordic_seq_if.sv | 32 +++
 rtl/cordic_seq.sv | 86 ++++++++
 2 files changed

// File: rtl/cordic_seq_if.sv
// cordic_seq_if: control/status bundle between a CORDIC sequencer and the
// block that drives it.
//   enable  : global clock-enable shared with the datapath
//   start   : operation request
//   abort   : synchronous cancel
//   ready   : sequencer idle
//   busy    : operand load or micro-rotations in progress
//   load    : datapath captures initial x, y, z
//   iter_en : datapath shift/add enable
//   iter    : iteration index / arctangent ROM address
//   done    : completion pulse
interface cordic_seq_if;
  logic       enable;
  logic       start;
  logic       abort;
  logic       ready;
  logic       busy;
  logic       load;
  logic       iter_en;
  logic [3:0] iter;
  logic       done;

  modport master (
    output enable, start, abort,
    input  ready, busy, load, iter_en, iter, done
  );

  modport slave (
    input  enable, start, abort,
    output ready, busy, load, iter_en, iter, done
  );
endinterface

// File: rtl/cordic_seq.sv
// cordic_seq: sequencing FSM for an iterative CORDIC datapath.
//   clock : rising-edge system clock
//   reset : asynchronous active-low reset
//   bus   : cordic_seq_if.slave (enable/start/abort in; ready, busy, load,
//           iter_en, iter, done out -- all Moore outputs)
//
// state | meaning
// IDLE  | waiting for start, ready=1
// LOAD  | one cycle, datapath captures operands
// ITER  | micro-rotations, iter counts 0..NITER-1
// DONE  | one cycle completion pulse
module cordic_seq #(
  parameter int NITER = 16
) (
  input  logic          clock,
  input  logic          reset,
  cordic_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ITER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0] LAST_ITER = 4'(NITER - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_iter;
  logic [3:0] w_iter_nxt;

  // Everything, including the counter, stalls when enable is low so a held
  // strobe never advances the shared datapath twice.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_iter  <= 4'd0;
    end else if (bus.enable) begin
      r_state <= w_state_nxt;
      r_iter  <= w_iter_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_iter_nxt  = r_iter;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_state_nxt = S_ITER;
        w_iter_nxt  = 4'd0;
      end
      S_ITER: begin
        // The final index is held into DONE, so NITER=16 never wraps to 0.
        if (r_iter == LAST_ITER) begin
          w_state_nxt = S_DONE;
        end else begin
          w_iter_nxt = r_iter + 4'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // abort overrides every other transition, including the start in IDLE.
    if (bus.abort) begin
      w_state_nxt = S_IDLE;
      w_iter_nxt  = 4'd0;
    end
  end

  assign bus.ready   = (r_state == S_IDLE);
  assign bus.busy    = (r_state == S_LOAD) || (r_state == S_ITER);
  assign bus.load    = (r_state == S_LOAD);
  assign bus.iter_en = (r_state == S_ITER);
  assign bus.done    = (r_state == S_DONE);
  assign bus.iter    = r_iter;

endmodule
